// File: rtl/ctl_game.sv
// Game-flow controller: sequences ducks, tracks ammo/score as BCD and drives
// the launch/kill/escape strobes for the duck controller.
// Optional build macro CTL_GAME_PERFECT_BONUS_EN adds a perfect-game bonus
// and the bonus_flag output.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | after reset, waiting for start
// LAUNCH    | one cycle: reload ammo, pulse duck_launch
// FLYING    | duck catchable; shots, hits, misses and timeout counted
// FALLING   | duck hit, waiting END_FRAMES frames
// ESCAPE    | duck escaped, waiting END_FRAMES frames
// GAME_OVER | score held until the next start
module ctl_game #(
  parameter int AMMO_PER_DUCK      = 3,
  parameter int DUCKS_PER_GAME     = 10,
  parameter int SCORE_DIGITS       = 2,
  parameter int HIT_POINTS         = 1,
  parameter int FLY_TIMEOUT_FRAMES = 300,
  parameter int END_FRAMES         = 60,
  parameter int BONUS_POINTS       = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      new_frame,
  input  logic                      start,
  input  logic                      shot_fired,
  input  logic                      hit,
  input  logic                      miss,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic [7:0]                ammo_bcd,
  output logic [7:0]                ducks_left,
  output logic                      duck_launch,
  output logic                      duck_kill,
  output logic                      duck_escape,
  output logic                      game_over,
  output logic                      playing
`ifdef CTL_GAME_PERFECT_BONUS_EN
  ,
  output logic                      bonus_flag
`endif
);

  localparam int SW   = 4 * SCORE_DIGITS;
  localparam int TMAX = (FLY_TIMEOUT_FRAMES > END_FRAMES) ? FLY_TIMEOUT_FRAMES : END_FRAMES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [7:0]    AMMO_LOAD = 8'(((AMMO_PER_DUCK / 10) << 4) | (AMMO_PER_DUCK % 10));
  localparam logic [7:0]    DUCKS_ALL = 8'(DUCKS_PER_GAME);
  localparam logic [TW-1:0] FLY_LAST  = TW'(FLY_TIMEOUT_FRAMES - 1);
  localparam logic [TW-1:0] END_LAST  = TW'(END_FRAMES - 1);
  localparam logic [3:0]    HIT_INC   = 4'(HIT_POINTS);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, FLYING, FALLING, ESCAPE, GAME_OVER
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [SW-1:0] score_nxt;
  logic [7:0]    ammo_nxt, ducks_nxt;
  logic          launch_nxt, kill_nxt, escape_nxt, over_nxt, playing_nxt;
`ifdef CTL_GAME_PERFECT_BONUS_EN
  localparam logic [3:0] BONUS_INC = 4'(BONUS_POINTS);
  logic [7:0] hits, hits_nxt;
  logic       bonus_nxt;
`endif

  // Ripple of per-digit add-with-6-correct; a carry out of the top digit
  // pins the score at all nines.
  function automatic logic [SW-1:0] bcd_add(input logic [SW-1:0] a, input logic [3:0] b);
    logic [SW-1:0] r;
    logic [4:0]    d;
    logic          c;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      d = {1'b0, a[4*i +: 4]} + {4'b0, c} + ((i == 0) ? {1'b0, b} : 5'd0);
      if (d > 5'd9) begin
        d = d + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[4*i +: 4] = d[3:0];
    end
    if (c) r = {SCORE_DIGITS{4'h9}};
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] a);
    if (a[3:0] == 4'h0) return {a[7:4] - 4'h1, 4'h9};
    return {a[7:4], a[3:0] - 4'h1};
  endfunction

  // State and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      timer       <= '0;
      score_bcd   <= '0;
      ammo_bcd    <= AMMO_LOAD;
      ducks_left  <= DUCKS_ALL;
      duck_launch <= 1'b0;
      duck_kill   <= 1'b0;
      duck_escape <= 1'b0;
      game_over   <= 1'b0;
      playing     <= 1'b0;
`ifdef CTL_GAME_PERFECT_BONUS_EN
      hits        <= '0;
      bonus_flag  <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      score_bcd   <= score_nxt;
      ammo_bcd    <= ammo_nxt;
      ducks_left  <= ducks_nxt;
      duck_launch <= launch_nxt;
      duck_kill   <= kill_nxt;
      duck_escape <= escape_nxt;
      game_over   <= over_nxt;
      playing     <= playing_nxt;
`ifdef CTL_GAME_PERFECT_BONUS_EN
      hits        <= hits_nxt;
      bonus_flag  <= bonus_nxt;
`endif
    end
  end

  // Next-state logic and next values of every registered output.
  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    score_nxt  = score_bcd;
    ammo_nxt   = ammo_bcd;
    ducks_nxt  = ducks_left;
    kill_nxt   = 1'b0;
    escape_nxt = 1'b0;
`ifdef CTL_GAME_PERFECT_BONUS_EN
    hits_nxt   = hits;
    bonus_nxt  = bonus_flag;
`endif
    case (state)
      IDLE: begin
        if (start) state_nxt = LAUNCH;
      end
      LAUNCH: state_nxt = FLYING;
      FLYING: begin
        if (new_frame) timer_nxt = timer + 1'b1;
        // Same-cycle shot still spends ammo even when the hit wins.
        if (shot_fired && ammo_bcd != 8'h00) ammo_nxt = bcd_dec(ammo_bcd);
        if (hit) begin
          score_nxt = bcd_add(score_bcd, HIT_INC);
          kill_nxt  = 1'b1;
          timer_nxt = '0;
          state_nxt = FALLING;
`ifdef CTL_GAME_PERFECT_BONUS_EN
          hits_nxt  = hits + 8'd1;
`endif
        end else if ((new_frame && timer == FLY_LAST) || (miss && ammo_bcd == 8'h00)) begin
          escape_nxt = 1'b1;
          timer_nxt  = '0;
          state_nxt  = ESCAPE;
        end
      end
      FALLING, ESCAPE: begin
        if (new_frame) begin
          if (timer == END_LAST) begin
            timer_nxt = '0;
            ducks_nxt = ducks_left - 8'd1;
            if (ducks_left == 8'd1) begin
              state_nxt = GAME_OVER;
`ifdef CTL_GAME_PERFECT_BONUS_EN
              if (hits == DUCKS_ALL) begin
                score_nxt = bcd_add(score_bcd, BONUS_INC);
                bonus_nxt = 1'b1;
              end
`endif
            end else begin
              state_nxt = LAUNCH;
            end
          end else begin
            timer_nxt = timer + 1'b1;
          end
        end
      end
      GAME_OVER: begin
        if (start) begin
          score_nxt = '0;
          ducks_nxt = DUCKS_ALL;
          state_nxt = LAUNCH;
`ifdef CTL_GAME_PERFECT_BONUS_EN
          hits_nxt  = '0;
          bonus_nxt = 1'b0;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Reload happens on the way into LAUNCH so ammo is valid with the strobe.
    if (state_nxt == LAUNCH) begin
      ammo_nxt  = AMMO_LOAD;
      timer_nxt = '0;
    end
    launch_nxt  = (state_nxt == LAUNCH);
    over_nxt    = (state_nxt == GAME_OVER);
    playing_nxt = (state_nxt == LAUNCH) || (state_nxt == FLYING) ||
                  (state_nxt == FALLING) || (state_nxt == ESCAPE);
  end

endmodule

// File: tb/tb_ctl_game.sv
// Scoreboard bench for ctl_game. Two instances share stimulus: the default
// build and a one-digit, 4-points-per-hit build that exercises saturation.
module tb_ctl_game;

  localparam int AMMO  = 3;
  localparam int DUCKS = 10;
  localparam int FLY   = 300;
  localparam int ENDF  = 60;
  localparam int BONUS = 5;

  localparam int S_SCORE0 = 0, S_SCORE1 = 1, S_AMMO = 2, S_DUCKS = 3, S_LAUNCH = 4,
                 S_KILL = 5, S_ESC = 6, S_GO = 7, S_PLAY = 8, S_BONUS = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic new_frame = 1'b0, start = 1'b0, shot_fired = 1'b0, hit = 1'b0, miss = 1'b0;

  logic [7:0] score0, ammo0, ducks0, ammo1, ducks1;
  logic [3:0] score1;
  logic launch0, kill0, esc0, go0, play0, bonus0;
  logic launch1, kill1, esc1, go1, play1, bonus1;

  always #5 clk = ~clk;

  ctl_game u_dut0 (
    .clk(clk), .rst(rst), .new_frame(new_frame), .start(start),
    .shot_fired(shot_fired), .hit(hit), .miss(miss),
    .score_bcd(score0), .ammo_bcd(ammo0), .ducks_left(ducks0),
    .duck_launch(launch0), .duck_kill(kill0), .duck_escape(esc0),
    .game_over(go0), .playing(play0)
`ifdef CTL_GAME_PERFECT_BONUS_EN
    , .bonus_flag(bonus0)
`endif
  );

  ctl_game #(.SCORE_DIGITS(1), .HIT_POINTS(4)) u_dut1 (
    .clk(clk), .rst(rst), .new_frame(new_frame), .start(start),
    .shot_fired(shot_fired), .hit(hit), .miss(miss),
    .score_bcd(score1), .ammo_bcd(ammo1), .ducks_left(ducks1),
    .duck_launch(launch1), .duck_kill(kill1), .duck_escape(esc1),
    .game_over(go1), .playing(play1)
`ifdef CTL_GAME_PERFECT_BONUS_EN
    , .bonus_flag(bonus1)
`endif
  );

`ifndef CTL_GAME_PERFECT_BONUS_EN
  assign bonus0 = 1'b0;
  assign bonus1 = 1'b0;
`endif

  typedef struct {
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  int   m_ammo, m_ducks, m_s0, m_s1, m_hits;
  logic m_bonus;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_SCORE0: return {24'h0, score0};
      S_SCORE1: return {28'h0, score1};
      S_AMMO:   return {24'h0, ammo0};
      S_DUCKS:  return {24'h0, ducks0};
      S_LAUNCH: return {31'h0, launch0};
      S_KILL:   return {31'h0, kill0};
      S_ESC:    return {31'h0, esc0};
      S_GO:     return {31'h0, go0};
      S_PLAY:   return {31'h0, play0};
      default:  return {31'h0, bonus0};
    endcase
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      S_SCORE0: return "score_bcd";
      S_SCORE1: return "score_bcd_1digit";
      S_AMMO:   return "ammo_bcd";
      S_DUCKS:  return "ducks_left";
      S_LAUNCH: return "duck_launch";
      S_KILL:   return "duck_kill";
      S_ESC:    return "duck_escape";
      S_GO:     return "game_over";
      S_PLAY:   return "playing";
      default:  return "bonus_flag";
    endcase
  endfunction

  task automatic push(input int sel, input logic [31:0] exp);
    exp_t e;
    e.sel = sel;
    e.exp = exp;
    q.push_back(e);
  endtask

  task automatic push_scores();
    push(S_SCORE0, to_bcd(m_s0));
    push(S_SCORE1, to_bcd(m_s1));
  endtask

  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk(sel_name(e.sel), obs(e.sel), e.exp);
    end
  endtask

  // One clock with the currently driven inputs, then compare what is pending.
  task automatic cyc();
    @(posedge clk);
    #1;
    new_frame = 1'b0; start = 1'b0; shot_fired = 1'b0; hit = 1'b0; miss = 1'b0;
    drain();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      new_frame = 1'b1;
      cyc();
    end
  endtask

  task automatic go_start();
    start = 1'b1;
    m_ammo = AMMO; m_ducks = DUCKS; m_s0 = 0; m_s1 = 0; m_hits = 0; m_bonus = 1'b0;
    push(S_LAUNCH, 1); push(S_AMMO, to_bcd(AMMO)); push(S_DUCKS, DUCKS);
    push(S_PLAY, 1); push(S_GO, 0); push(S_BONUS, 0);
    push_scores();
    cyc();
    push(S_LAUNCH, 0); push(S_PLAY, 1);
    cyc();
  endtask

  task automatic shoot();
    shot_fired = 1'b1;
    if (m_ammo > 0) m_ammo--;
    push(S_AMMO, to_bcd(m_ammo));
    cyc();
  endtask

  task automatic do_hit(input bit with_shot);
    hit = 1'b1;
    if (with_shot) begin
      shot_fired = 1'b1;
      if (m_ammo > 0) m_ammo--;
    end
    m_s0 = sat(m_s0 + 1, 99);
    m_s1 = sat(m_s1 + 4, 9);
    m_hits++;
    push(S_KILL, 1); push(S_ESC, 0); push(S_AMMO, to_bcd(m_ammo));
    push_scores();
    cyc();
    push(S_KILL, 0);
    cyc();
  endtask

  task automatic escape_by_miss();
    miss = 1'b1;
    push(S_ESC, 1); push(S_KILL, 0);
    cyc();
    push(S_ESC, 0);
    cyc();
  endtask

  task automatic end_phase(input bit junk);
    if (junk) begin
      shot_fired = 1'b1; hit = 1'b1; miss = 1'b1;
      push(S_KILL, 0); push(S_ESC, 0); push(S_AMMO, to_bcd(m_ammo));
      push_scores();
      cyc();
    end
    push(S_DUCKS, m_ducks); push(S_PLAY, 1);
    frames(ENDF - 1);
    new_frame = 1'b1;
    m_ducks--;
    push(S_DUCKS, m_ducks);
    if (m_ducks == 0) begin
`ifdef CTL_GAME_PERFECT_BONUS_EN
      if (m_hits == DUCKS) begin
        m_s0 = sat(m_s0 + BONUS, 99);
        m_s1 = sat(m_s1 + BONUS, 9);
        m_bonus = 1'b1;
      end
`endif
      push(S_GO, 1); push(S_PLAY, 0); push(S_LAUNCH, 0); push(S_BONUS, m_bonus);
      push_scores();
      cyc();
    end else begin
      m_ammo = AMMO;
      push(S_LAUNCH, 1); push(S_AMMO, to_bcd(AMMO)); push(S_PLAY, 1);
      cyc();
      push(S_LAUNCH, 0);
      cyc();
    end
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    m_ammo = AMMO; m_ducks = DUCKS; m_s0 = 0; m_s1 = 0; m_hits = 0; m_bonus = 1'b0;
    push_scores(); push(S_AMMO, 8'h03); push(S_DUCKS, DUCKS); push(S_LAUNCH, 0);
    push(S_KILL, 0); push(S_ESC, 0); push(S_GO, 0); push(S_PLAY, 0); push(S_BONUS, 0);
    drain();
    @(negedge clk) rst = 1'b1;
    cyc();

    // Game 1
    go_start();
    // Duck 1: ammo runs dry, extra shot ignored, miss at zero escapes.
    repeat (4) shoot();
    escape_by_miss();
    end_phase(1'b0);
    // Duck 2: shot then hit five cycles later; junk during FALLING ignored.
    shoot();
    repeat (4) cyc();
    do_hit(1'b0);
    end_phase(1'b1);
    // Duck 3: timeout escape on the 300th frame.
    frames(FLY - 2);
    new_frame = 1'b1; push(S_ESC, 0);
    cyc();
    new_frame = 1'b1; push(S_ESC, 1); push(S_KILL, 0);
    cyc();
    end_phase(1'b0);
    // Duck 4: hit in the same cycle as the timeout frame, hit wins.
    frames(FLY - 1);
    new_frame = 1'b1;
    do_hit(1'b1);
    end_phase(1'b0);
    // Ducks 5..10: immediate hits.
    for (int d = 0; d < 6; d++) begin
      do_hit(1'b0);
      end_phase(1'b0);
    end
    // Game over holds score and ignores shots/hits.
    hit = 1'b1; shot_fired = 1'b1;
    push(S_GO, 1); push(S_KILL, 0); push_scores();
    cyc();

    // Game 2: perfect game; first duck hit at zero ammo; start ignored in FLYING.
    go_start();
    start = 1'b1; push(S_LAUNCH, 0); push(S_PLAY, 1);
    cyc();
    repeat (3) shoot();
    do_hit(1'b0);
    end_phase(1'b0);
    for (int d = 1; d < DUCKS; d++) begin
      do_hit(1'b0);
      end_phase(1'b0);
    end

    // Game 3: asynchronous reset mid-FLYING.
    go_start();
    shoot();
    #2 rst = 1'b0;
    #1;
    m_ammo = AMMO; m_ducks = DUCKS; m_s0 = 0; m_s1 = 0; m_bonus = 1'b0;
    push_scores(); push(S_AMMO, 8'h03); push(S_DUCKS, DUCKS); push(S_LAUNCH, 0);
    push(S_GO, 0); push(S_PLAY, 0); push(S_BONUS, 0);
    drain();
    @(negedge clk) rst = 1'b1;
    push(S_PLAY, 0); push(S_LAUNCH, 0);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
